// File: rtl/rot_shift_seq_if.sv
// Start/Busy/Done handshake bundle for the sequential shifter/rotator.
// The master is the issuing CPU side; the slave is the execution unit.
interface rot_shift_seq_if #(
  parameter int unsigned Width = 16
);
  logic             start;
  logic [2:0]       mode;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic [Width-1:0] result;
  logic             carry_out;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/rot_shift_seq.sv
// Multi-cycle rotate / logical shift / arithmetic shift unit, one bit position per clock.
// Result and carry_out update only when the operation finishes and hold until the next one.
module rot_shift_seq #(
  parameter int unsigned Width  = 16,
  parameter int unsigned ShamtW = $clog2(Width)
) (
  input logic           clk_i,
  input logic           rst_i,
  rot_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e              state_q;
  logic [Width-1:0]    work_q;
  logic [2:0]          mode_q;
  logic [ShamtW-1:0]   cnt_q;
  logic                carry_q;
  logic                busy_q;
  logic                done_q;
  logic [Width-1:0]    result_q;
  logic                carry_out_q;

  logic [ShamtW-1:0]   amt;
  logic                direct_fin;
  logic [Width-1:0]    step_val;
  logic                step_carry;
  logic [Width-1:0]    fin_val;
  logic                unused_b;

  assign amt      = bus.b[ShamtW-1:0];
  assign unused_b = ^bus.b[Width-1:ShamtW];

  // Zero amount, the legacy swap and pass-through skip the shift loop entirely.
  always_comb begin
    direct_fin = 1'b0;
    if (amt == '0 || bus.mode == 3'b101 || bus.mode[2:1] == 2'b11) begin
      direct_fin = 1'b1;
    end
  end

  always_comb begin
    step_val   = work_q;
    step_carry = 1'b0;
    case (mode_q)
      3'b000: begin
        step_val   = {work_q[0], work_q[Width-1:1]};
        step_carry = work_q[0];
      end
      3'b001: begin
        step_val   = {work_q[Width-2:0], work_q[Width-1]};
        step_carry = work_q[Width-1];
      end
      3'b010: begin
        step_val   = {1'b0, work_q[Width-1:1]};
        step_carry = work_q[0];
      end
      3'b011: begin
        step_val   = {work_q[Width-2:0], 1'b0};
        step_carry = work_q[Width-1];
      end
      3'b100: begin
        step_val   = {work_q[Width-1], work_q[Width-1:1]};
        step_carry = work_q[0];
      end
      default: begin
        step_val   = work_q;
        step_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    fin_val = work_q;
    if (mode_q == 3'b101) begin
      fin_val[0]       = work_q[Width-1];
      fin_val[Width-1] = work_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      work_q      <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            work_q  <= bus.a;
            mode_q  <= bus.mode;
            cnt_q   <= amt;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= direct_fin ? StFin : StShift;
          end
        end
        StShift: begin
          work_q  <= step_val;
          carry_q <= step_carry;
          cnt_q   <= cnt_q - ShamtW'(1);
          if (cnt_q == ShamtW'(1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          result_q    <= fin_val;
          carry_out_q <= carry_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_rot_shift_seq.sv
// Scoreboard bench for rot_shift_seq: the driver pushes model predictions, the monitor
// pops and compares on every done pulse, and checks result stability in between.
module tb_rot_shift_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rot_shift_seq_if #(.Width(W)) bus ();

  rot_shift_seq #(.Width(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    int unsigned  done_cyc;
    int unsigned  busy_len;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // Reference: whole-amount arithmetic on the operand, no per-step iteration.
  function automatic void model(input logic [2:0] mode, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] res,
                                output logic c, output int unsigned n_eff);
    int unsigned n;
    n     = b % W;
    res   = a;
    c     = 1'b0;
    n_eff = 0;
    if (mode == 3'b101) begin
      res[0]   = a[W-1];
      res[W-1] = a[0];
    end else if (mode[2:1] != 2'b11 && n != 0) begin
      n_eff = n;
      case (mode)
        3'd0: begin res = (a >> n) | (a << (W - n)); c = a[n-1]; end
        3'd1: begin res = (a << n) | (a >> (W - n)); c = a[W-n]; end
        3'd2: begin res = a >> n;                    c = a[n-1]; end
        3'd3: begin res = a << n;                    c = a[W-n]; end
        default: begin res = $signed(a) >>> n;       c = a[n-1]; end
      endcase
    end
  endfunction

  task automatic issue(input logic [2:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, input bit expect_done);
    logic [W-1:0] r;
    logic         c;
    int unsigned  ne;
    int unsigned  guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", bus.busy, 1'b0);
    model(mode, a, b, r, c, ne);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.a     = a;
    bus.b     = b;
    if (expect_done) sb_q.push_back('{r, c, cyc + 2 + ne, ne + 1});
    @(negedge clk);
    if (hold) begin
      // Start held while busy with different operands must be ignored.
      bus.a = ~a;
      bus.b = ~b;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Monitor
  int unsigned  busy_cnt = 0;
  logic [W-1:0] last_res = '0;
  logic         last_c   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
      last_res = '0;
      last_c   = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.result, e.res);
          chk("carry_out", bus.carry_out, e.carry);
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_len", busy_cnt, e.busy_len);
        end
        busy_cnt = 0;
        last_res = bus.result;
        last_c   = bus.carry_out;
      end else begin
        chk("result_hold", {bus.carry_out, bus.result}, {last_c, last_res});
      end
    end
  end

  initial begin
    int unsigned guard;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_carry", bus.carry_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b000, 16'h0001, 16'd1, 1'b0, 1'b1);
    issue(3'b001, 16'h8001, 16'd4, 1'b0, 1'b1);
    issue(3'b100, 16'h8000, 16'd15, 1'b0, 1'b1);
    issue(3'b010, 16'h1234, 16'hFFF0, 1'b0, 1'b1);
    issue(3'b101, 16'h8000, 16'd7, 1'b1, 1'b1);

    // Abort: reset at the third edge after acceptance.
    issue(3'b000, 16'hFFFF, 16'd10, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, '0);
    chk("abort_carry", bus.carry_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
            ($urandom_range(0, 3) == 0), 1'b1);
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", sb_q.size(), 0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
